// File: rtl/pb_cluster_irq_ctrl.sv
// Cluster interrupt aggregator for picobello: latches cluster IRQ events into PENDING,
// masks them with ENABLE and drives one registered external IRQ line per cluster.
// Optional macro PB_IRQ_EDGE_DETECT_EN: defined -> rising-edge events, undefined -> level-sticky.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no response outstanding, a request is accepted at once
// ST_RESP | response held on rsp_*; a new request is accepted only
//         | in the cycle the current response is consumed
module pb_cluster_irq_ctrl #(
  parameter int unsigned NumClusters = 4,
  parameter int unsigned SyncStages  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] cluster_irq_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [3:0]             req_addr_i,
  input  logic [31:0]            req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NumClusters-1:0] ext_irq_o
);

  if (NumClusters < 1 || NumClusters > 32) begin : g_bad_num_clusters
    $error("pb_cluster_irq_ctrl: NumClusters must be within 1..32");
  end
  if (SyncStages > 2) begin : g_bad_sync_stages
    $error("pb_cluster_irq_ctrl: SyncStages must be within 0..2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic [1:0] RegPending = 2'd0;
  localparam logic [1:0] RegEnable  = 2'd1;
  localparam logic [1:0] RegSet     = 2'd2;
  localparam logic [1:0] RegCount   = 2'd3;

  state_e                   state_q;
  logic                     rsp_valid_q;
  logic [31:0]              rsp_rdata_q;
  logic                     rsp_error_q;

  logic [NumClusters-1:0]   pending_q;
  logic [NumClusters-1:0]   enable_q;
  logic [15:0]              count_q;
  logic [NumClusters-1:0]   ext_irq_q;

  logic [NumClusters-1:0]   irq_sync;
  logic [NumClusters-1:0]   hw_set;

  logic                     accept;
  logic                     wr_acc;
  logic [1:0]               reg_sel;
  logic [NumClusters-1:0]   wdata_m;
  logic [NumClusters-1:0]   sw_clr;
  logic [NumClusters-1:0]   sw_set;
  logic                     enable_we;
  logic                     count_clr;
  logic [NumClusters-1:0]   set_vec;
  logic [NumClusters-1:0]   new_set;
  logic [NumClusters-1:0]   pending_d;
  logic [5:0]               new_cnt;
  logic [16:0]              count_sum;
  logic [15:0]              count_d;
  logic [31:0]              rdata_d;
  logic                     error_d;

  // Byte-lane bits and write data above NumClusters carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{req_addr_i[1:0], req_wdata_i};

  function automatic logic [5:0] popcount(input logic [NumClusters-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < int'(NumClusters); i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // Optional input synchroniser
  if (SyncStages == 0) begin : g_no_sync
    assign irq_sync = cluster_irq_i;
  end else begin : g_sync
    logic [NumClusters-1:0] sync_q [SyncStages];
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(SyncStages); i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q[0] <= cluster_irq_i;
        for (int i = 1; i < int'(SyncStages); i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
    assign irq_sync = sync_q[SyncStages-1];
  end

`ifdef PB_IRQ_EDGE_DETECT_EN
  // Events stay masked until the synchroniser and edge history have refilled after
  // reset, so a source held high across reset never looks like a fresh edge.
  localparam logic [1:0] PrimeCycles = 2'(SyncStages + 1);

  logic [NumClusters-1:0] irq_prev_q;
  logic [1:0]             prime_cnt_q;
  logic                   primed;

  assign primed = (prime_cnt_q == PrimeCycles);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_prev_q  <= '0;
      prime_cnt_q <= '0;
    end else begin
      irq_prev_q <= irq_sync;
      if (!primed) begin
        prime_cnt_q <= prime_cnt_q + 2'd1;
      end
    end
  end

  assign hw_set = irq_sync & ~irq_prev_q & {NumClusters{primed}};
`else
  assign hw_set = irq_sync;
`endif

  assign req_ready_o = (state_q == ST_IDLE) || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr_acc      = accept && req_write_i;
  assign reg_sel     = req_addr_i[3:2];
  assign wdata_m     = req_wdata_i[NumClusters-1:0];

  assign sw_clr    = (wr_acc && reg_sel == RegPending) ? wdata_m : '0;
  assign sw_set    = (wr_acc && reg_sel == RegSet)     ? wdata_m : '0;
  assign enable_we = wr_acc && (reg_sel == RegEnable);
  assign count_clr = wr_acc && (reg_sel == RegCount);

  // Set beats clear; only 0->1 transitions of PENDING are counted as events.
  assign set_vec   = hw_set | sw_set;
  assign new_set   = set_vec & ~pending_q;
  assign pending_d = (pending_q & ~sw_clr) | set_vec;
  assign new_cnt   = popcount(new_set);
  assign count_sum = {1'b0, count_q} + 17'(new_cnt);

  always_comb begin
    count_d = count_sum[15:0];
    if (count_clr) begin
      count_d = 16'(new_cnt);
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end
  end

  // Read data reflects register contents before this cycle's side effects.
  always_comb begin
    rdata_d = '0;
    error_d = 1'b0;
    if (!req_write_i) begin
      unique case (reg_sel)
        RegPending: rdata_d = 32'(pending_q);
        RegEnable:  rdata_d = 32'(enable_q);
        RegSet: begin
          rdata_d = '0;
          error_d = 1'b1;
        end
        RegCount:   rdata_d = 32'(count_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      enable_q  <= '0;
      count_q   <= '0;
      ext_irq_q <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      if (enable_we) begin
        enable_q <= wdata_m;
      end
      ext_irq_q <= pending_q & enable_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_error_q <= error_d;
          end
        end
        ST_RESP: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_error_q <= error_d;
          end else if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign ext_irq_o   = ext_irq_q;

endmodule

// File: tb/tb_pb_cluster_irq_ctrl.sv
// Directed self-checking bench for pb_cluster_irq_ctrl with four clusters and no
// input synchroniser; expectations follow PB_IRQ_EDGE_DETECT_EN when it is defined.
module tb_pb_cluster_irq_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  cluster_irq = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [3:0]    req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [N-1:0]  ext_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_rst_pend;
  logic [31:0] exp_rst_count;

  pb_cluster_irq_ctrl #(.NumClusters(N), .SyncStages(0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cluster_irq_i(cluster_irq),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .ext_irq_o    (ext_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One accepted transaction, consumed in the cycle after acceptance.
  task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic err);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("bus_rsp_valid", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_error;
    cyc();
  endtask

  initial begin
`ifdef PB_IRQ_EDGE_DETECT_EN
    exp_rst_pend  = 32'h0;
    exp_rst_count = 32'h0;
`else
    exp_rst_pend  = 32'hF;
    exp_rst_count = 32'h4;
`endif

    // Reset with all sources held high across deassertion
    cluster_irq = 4'hF;
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_ext_irq", 32'(ext_irq), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    repeat (2) cyc();
    cluster_irq = '0;
    cyc();
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("post_rst_pending", rd, exp_rst_pend);
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("post_rst_count", rd, exp_rst_count);
    bus(1'b0, 4'h4, 32'h0, rd, er);
    chk("post_rst_enable", rd, 32'h0);
    bus(1'b1, 4'h0, 32'hF, rd, er);
    bus(1'b1, 4'hC, 32'h0, rd, er);

    // ENABLE masking of bits above NumClusters
    bus(1'b1, 4'h4, 32'hFFFF_FFFF, rd, er);
    chk("write_rdata_zero", rd, 32'h0);
    bus(1'b0, 4'h5, 32'h0, rd, er);
    chk("enable_masked", rd, 32'hF);
    bus(1'b1, 4'h4, 32'h1, rd, er);
    bus(1'b0, 4'h4, 32'h0, rd, er);
    chk("enable_readback", rd, 32'h1);

    // One-cycle pulse on bit 0
    cluster_irq = 4'h1;
    cyc();
    cluster_irq = 4'h0;
    chk("ext_irq_edge_plus1", 32'(ext_irq), 32'h0);
    cyc();
    chk("ext_irq_edge_plus2", 32'(ext_irq), 32'h1);
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("pulse_pending", rd, 32'h1);
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("pulse_count", rd, 32'h1);

    // Clear of bit 0 in the same cycle as a new event on bit 0
    cluster_irq = 4'h1;
    bus(1'b1, 4'h0, 32'h1, rd, er);
    cluster_irq = 4'h0;
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("set_beats_clear_pending", rd, 32'h1);
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("set_beats_clear_count", rd, 32'h1);
    bus(1'b1, 4'h0, 32'h1, rd, er);
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("w1c_pending", rd, 32'h0);
    chk("w1c_ext_irq", 32'(ext_irq), 32'h0);

    // Response held under backpressure
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h4;
    rsp_ready = 1'b0;
    cyc();
    req_addr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("bp_released", 32'(rsp_valid), 32'd0);

    // SET register: read error, write-1-to-set
    bus(1'b0, 4'h8, 32'h0, rd, er);
    chk("set_read_err", 32'(er), 32'd1);
    chk("set_read_rdata", rd, 32'h0);
    bus(1'b1, 4'h8, 32'hFFFF_FFFF, rd, er);
    chk("set_write_err", 32'(er), 32'd0);
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("set_pending", rd, 32'hF);
    chk("set_ext_irq", 32'(ext_irq), 32'h1);

    // Back-to-back reads accepted while the first response is consumed
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h4;
    rsp_ready = 1'b1;
    cyc();
    chk("b2b_first", rsp_rdata, 32'h1);
    req_addr = 4'hC;
    cyc();
    req_valid = 1'b0;
    chk("b2b_second_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_second_count", rsp_rdata, 32'h5);
    cyc();

    // COUNT clear coinciding with a new event loads that event
    bus(1'b1, 4'h0, 32'hF, rd, er);
    cluster_irq = 4'h2;
    bus(1'b1, 4'hC, 32'h0, rd, er);
    cluster_irq = 4'h0;
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("count_clr_with_set", rd, 32'h1);

    // Saturation: 70000 events with continuous clearing of PENDING
    bus(1'b1, 4'h0, 32'hF, rd, er);
    bus(1'b1, 4'hC, 32'h0, rd, er);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'h0;
    req_wdata = 32'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 17500; i++) begin
      cluster_irq = 4'hF;
      cyc();
      cluster_irq = 4'h0;
      cyc();
    end
    req_valid = 1'b0;
    cyc();
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("count_saturated", rd, 32'hFFFF);
    bus(1'b0, 4'h0, 32'h0, rd, er);
    chk("sat_pending_cleared", rd, 32'h0);
    bus(1'b1, 4'hC, 32'h0, rd, er);
    bus(1'b0, 4'hC, 32'h0, rd, er);
    chk("count_cleared", rd, 32'h0);

    // Reset while a response is outstanding drops it
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h4;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("rst_resp_before", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_resp_dropped", 32'(rsp_valid), 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("rst_resp_no_replay", 32'(rsp_valid), 32'd0);
    bus(1'b0, 4'h4, 32'h0, rd, er);
    chk("rst_enable_zero", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_cluster_irq_ctrl.md
PB_CLUSTER_IRQ_CTRL -- requirements
Module: pb_cluster_irq_ctrl

Interface
REQ-001 SHALL have parameter NumClusters, default picobello_pkg::NumClusters, number of cluster interrupt sources and Cheshire external IRQ lines, legal range 1..32.
REQ-002 SHALL have parameter SyncStages, default 0, extra input register stages on cluster_irq_i, legal range 0..2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 cluster_irq_i  input  NumClusters  level interrupt request from each cluster.
REQ-006 req_valid_i  input  1  register request valid.
REQ-007 req_ready_o  output  1  register request accepted when high with req_valid_i.
REQ-008 req_write_i  input  1  1 = write, 0 = read.
REQ-009 req_addr_i  input  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
REQ-010 req_wdata_i  input  32  write data.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-013 rsp_rdata_o  output  32  read data; 0 for writes.
REQ-014 rsp_error_o  output  1  access error flag.
REQ-015 ext_irq_o  output  NumClusters  registered interrupt lines to Cheshire external IRQ inputs, one per hart/cluster.

Function
REQ-016 Registers: 0x0 PENDING (read; write-1-to-clear), 0x4 ENABLE (read/write), 0x8 SET (write-only, write-1-to-set PENDING; reads 0 with error), 0xC COUNT (read-only, saturating 16-bit count of pending-set events, zero-extended; write clears it).
REQ-017 Bits at or above NumClusters SHALL read 0 and ignore writes.
REQ-018 Request FSM states IDLE and RESP; IDLE->RESP on req_valid_i && req_ready_o; RESP->IDLE on rsp_ready_i, or RESP->RESP if a new request is accepted in the same cycle.
REQ-019 req_ready_o = (state==IDLE) || rsp_ready_i; at most one outstanding response.
REQ-020 Response SHALL be valid exactly one cycle after acceptance; register side effects take effect in the acceptance cycle; rsp_* held stable until consumed.
REQ-021 Source event per bit: rising edge of the synchronised cluster_irq_i (see Configuration); sets PENDING bit next cycle.
REQ-022 Same-cycle hardware set and software clear of one bit: set SHALL win.
REQ-023 COUNT SHALL add the number of bits newly set in PENDING that cycle, saturating at 0xFFFF; a clear-write with a simultaneous set SHALL load the new set count.
REQ-024 ext_irq_o SHALL equal the registered value of PENDING & ENABLE: one cycle after the PENDING/ENABLE update, two cycles after the source edge with SyncStages=0.
REQ-025 rsp_error_o SHALL be 1 for reads of SET only; all addresses are otherwise valid.

Reset
REQ-026 On rst_i: PENDING=0, ENABLE=0, COUNT=0, edge/sync registers=0, FSM=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, ext_irq_o=0.
REQ-027 A source held high through reset deassertion SHALL NOT produce an event (edge history resets to 0 but is reloaded in the first post-reset cycle without setting PENDING).
REQ-028 Reset during RESP SHALL drop the response; it is not replayed.

Configuration
REQ-029 Macro PB_IRQ_EDGE_DETECT_EN: defined -> event = rising edge per REQ-021; undefined -> PENDING bit is set every cycle the synchronised source is high (level-sticky), a clear while the source is high is overridden per REQ-022, and REQ-027 does not apply.

Verification
REQ-030 Write ENABLE=0x1, pulse cluster_irq_i[0] for 1 cycle -> PENDING reads 0x1, ext_irq_o[0]=1 two cycles after the edge, COUNT=1.
REQ-031 Write PENDING=0x1 in the same cycle as a new edge on bit 0 -> PENDING stays 0x1, COUNT=1.
REQ-032 Hold rsp_ready_i=0 for 5 cycles after a read of 0x4 -> rsp_valid_o, rsp_rdata_o stable, req_ready_o=0; no second request accepted.
REQ-033 Read 0x8 -> rsp_error_o=1, rsp_rdata_o=0; write SET=0xFFFFFFFF with NumClusters=4 -> PENDING=0xF.
REQ-034 Generate 70000 edges -> COUNT reads 0xFFFF; write 0xC -> reads 0.
REQ-035 cluster_irq_i=all-ones across rst_i deassertion, macro defined -> PENDING=0; macro undefined -> PENDING=all valid bits.
